// File: rtl/video_scan_reader.sv
// Raster scan-out engine: generates video timing, addresses the frame RAM and emits RGB/sync.
// Define H_PIXEL_DOUBLE_EN to stretch each stored pixel over two output pixels horizontally.
module video_scan_reader #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned H_OFFSET  = 0,
    parameter int unsigned V_OFFSET  = 0,
    parameter int unsigned BUF_LINE  = 640,
    parameter int unsigned ADDR_BITS = 15,
    parameter int unsigned RAM_WORDS = 32768
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 starttrigger,
    input  logic [1:0]           line_repeat,
    input  logic [23:0]          rddata,
    output logic [ADDR_BITS-1:0] rdaddr,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 DrawArea,
    output logic                 frame_start
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned XW = $clog2(H_TOTAL);
    localparam int unsigned YW = $clog2(V_TOTAL);
    localparam int unsigned CW = $clog2(BUF_LINE);

    localparam logic [XW-1:0] X_LO     = XW'(H_OFFSET);
    localparam logic [XW-1:0] X_HI     = XW'(H_VISIBLE - H_OFFSET);
    localparam logic [XW-1:0] X_VIS    = XW'(H_VISIBLE);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW:0]   X_HS_ON  = (XW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [XW:0]   X_HS_OFF = (XW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] Y_LO     = YW'(V_OFFSET);
    localparam logic [YW-1:0] Y_HI     = YW'(V_VISIBLE - V_OFFSET);
    localparam logic [YW-1:0] Y_VIS    = YW'(V_VISIBLE);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW:0]   Y_VS_ON  = (YW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [YW:0]   Y_VS_OFF = (YW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] COL_LAST = CW'(BUF_LINE - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_STEP  = ADDR_BITS'(BUF_LINE);
    localparam logic [ADDR_BITS:0]   BASE_LIMIT = (ADDR_BITS+1)'(RAM_WORDS - BUF_LINE);

    typedef enum logic {StIdle, StRun} state_t;

    state_t                 state;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [CW-1:0]          col;
    logic [ADDR_BITS-1:0]   line_base;
    logic [1:0]             rep, rep_cnt;
    logic                   win_p1, draw_p1, hs_p1, vs_p1, fs_p1;
    logic                   run, x_lo_ok, y_lo_ok, row_w, in_w, line_end, frame_end;
    logic                   hs_act, vs_act, adv, base_wrap;
    logic [XW:0]            x_ext;
    logic [YW:0]            y_ext;

    if (H_OFFSET == 0) begin : g_x_lo_none
        assign x_lo_ok = 1'b1;
    end else begin : g_x_lo
        assign x_lo_ok = x >= X_LO;
    end
    if (V_OFFSET == 0) begin : g_y_lo_none
        assign y_lo_ok = 1'b1;
    end else begin : g_y_lo
        assign y_lo_ok = y >= Y_LO;
    end

    assign run       = state == StRun;
    assign x_ext     = {1'b0, x};
    assign y_ext     = {1'b0, y};
    assign row_w     = y_lo_ok && y < Y_HI;
    assign in_w      = run && row_w && x_lo_ok && x < X_HI;
    assign line_end  = x == X_LAST;
    assign frame_end = line_end && y == Y_LAST;
    assign hs_act    = x_ext >= X_HS_ON && x_ext < X_HS_OFF;
    // vsync edges line up with the hsync leading edge, not with the line start
    assign vs_act    = (y_ext > Y_VS_ON || (y_ext == Y_VS_ON && x_ext >= X_HS_ON)) &&
                       (y_ext < Y_VS_OFF || (y_ext == Y_VS_OFF && x_ext < X_HS_ON));
    assign base_wrap = ({1'b0, line_base} + {1'b0, ADDR_STEP}) > BASE_LIMIT;
    assign rdaddr    = in_w ? line_base + ADDR_BITS'(col) : '0;

`ifdef H_PIXEL_DOUBLE_EN
    logic phase;
    assign adv = in_w && phase;
`else
    assign adv = in_w;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= StIdle;
            x           <= X_LO;
            y           <= Y_LO;
            col         <= '0;
            line_base   <= '0;
            rep         <= '0;
            rep_cnt     <= '0;
            win_p1      <= 1'b0;
            draw_p1     <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
            fs_p1       <= 1'b0;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            DrawArea    <= 1'b0;
            frame_start <= 1'b0;
`ifdef H_PIXEL_DOUBLE_EN
            phase       <= 1'b0;
`endif
        end else begin
            // Stage 1 lines up with the RAM read; stage 2 is the output register.
            win_p1      <= in_w;
            draw_p1     <= run && x < X_VIS && y < Y_VIS;
            hs_p1       <= run && hs_act;
            vs_p1       <= run && vs_act;
            fs_p1       <= run && x == '0 && y == '0;
            red         <= win_p1 ? rddata[23:16] : 8'h00;
            green       <= win_p1 ? rddata[15:8] : 8'h00;
            blue        <= win_p1 ? rddata[7:0] : 8'h00;
            hsync       <= hs_p1 ? H_POL : ~H_POL;
            vsync       <= vs_p1 ? V_POL : ~V_POL;
            DrawArea    <= draw_p1;
            frame_start <= fs_p1;
            case (state)
                StIdle: begin
                    if (starttrigger) begin
                        state     <= StRun;
                        x         <= X_LO;
                        y         <= Y_LO;
                        col       <= '0;
                        line_base <= '0;
                        rep_cnt   <= '0;
                        rep       <= line_repeat;
                    end
                end
                StRun: begin
                    if (line_end) begin
                        x   <= '0;
                        col <= '0;
`ifdef H_PIXEL_DOUBLE_EN
                        phase <= 1'b0;
`endif
                        if (frame_end) begin
                            y         <= '0;
                            line_base <= '0;
                            rep_cnt   <= '0;
                            rep       <= line_repeat;
                        end else begin
                            y <= y + 1'b1;
                            if (row_w) begin
                                if (rep_cnt == rep) begin
                                    rep_cnt   <= '0;
                                    line_base <= base_wrap ? '0 : line_base + ADDR_STEP;
                                end else begin
                                    rep_cnt <= rep_cnt + 2'd1;
                                end
                            end
                        end
                    end else begin
                        x <= x + 1'b1;
                        if (adv && col != COL_LAST) col <= col + 1'b1;
`ifdef H_PIXEL_DOUBLE_EN
                        if (in_w) phase <= ~phase;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_video_scan_reader.sv
// Self-checking bench for video_scan_reader on a tiny 14x7 raster with a 24-word RAM so the
// line-base wrap is exercised; expected values come from a frame-position model.
module tb_video_scan_reader;
    localparam int HV = 8, HF = 2, HSY = 2, HB = 2;
    localparam int VV = 4, VF = 1, VSY = 1, VB = 1;
    localparam int HO = 0, VO = 0, BUF = 8, AB = 8, RAM = 24;
    localparam bit H_POL = 1'b0, V_POL = 1'b0;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam int VS_ON_P  = (VV + VF) * HT + HV + HF;
    localparam int VS_OFF_P = (VV + VF + VSY) * HT + HV + HF;
`ifdef H_PIXEL_DOUBLE_EN
    localparam int DBL = 2;
`else
    localparam int DBL = 1;
`endif
    localparam logic [27:0] IDLE_VEC = {24'h0, ~H_POL, ~V_POL, 1'b0, 1'b0};

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          starttrigger = 1'b0;
    logic [1:0]    line_repeat = 2'd0;
    logic [23:0]   rddata = 24'h0;
    logic [AB-1:0] rdaddr;
    logic [7:0]    red, green, blue;
    logic          hsync, vsync, DrawArea, frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    video_scan_reader #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .H_POL(H_POL), .V_POL(V_POL), .H_OFFSET(HO), .V_OFFSET(VO),
        .BUF_LINE(BUF), .ADDR_BITS(AB), .RAM_WORDS(RAM)
    ) dut (
        .clock(clock), .reset(reset), .starttrigger(starttrigger), .line_repeat(line_repeat),
        .rddata(rddata), .rdaddr(rdaddr), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .DrawArea(DrawArea), .frame_start(frame_start)
    );

    function automatic logic [23:0] ram_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b ^ 8'hA5, b + 8'd17, b};
    endfunction

    // RAM read port: data for an address appears one clock later
    always @(posedge clock) rddata <= ram_word(int'(rdaddr));

    // Expected behaviour for the k-th clock after scan-out starts, frame line-repeat r.
    function automatic void model(input int k, input int r, output int addr,
                                  output logic [27:0] vec);
        int p, x, y, col, lines, base;
        bit w, da, hs, vs, fs;
        p = k % FT;
        x = p % HT;
        y = p / HT;
        w = x >= HO && x < HV - HO && y >= VO && y < VV - VO;
        addr = 0;
        if (w) begin
            col = (x - HO) / DBL;
            if (col > BUF - 1) col = BUF - 1;
            lines = (y - VO) / (r + 1);
            base = 0;
            for (int i = 0; i < lines; i++) base = (base + BUF > RAM - BUF) ? 0 : base + BUF;
            addr = base + col;
        end
        da = x < HV && y < VV;
        hs = x >= HV + HF && x < HV + HF + HSY;
        vs = p >= VS_ON_P && p < VS_OFF_P;
        fs = p == 0;
        vec = {w ? ram_word(addr) : 24'h0, hs ? H_POL : ~H_POL, vs ? V_POL : ~V_POL, da, fs};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        starttrigger = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic start_run(input int rep);
        @(negedge clock);
        line_repeat = 2'(rep);
        starttrigger = 1'b1;
        @(posedge clock);
        #1 starttrigger = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] got;
        reset = 1'b0;
        starttrigger = 1'b1;
        line_repeat = 2'($urandom);
        repeat (5) @(posedge clock);
        #1;
        got = {red, green, blue, hsync, vsync, DrawArea, frame_start};
        checks++;
        if (got !== IDLE_VEC || rdaddr !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h/%h exp %h/0", got, rdaddr, IDLE_VEC);
        end
        @(negedge clock);
        starttrigger = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            line_repeat = 2'($urandom);
            got = {red, green, blue, hsync, vsync, DrawArea, frame_start};
            checks++;
            if (got !== IDLE_VEC || rdaddr !== '0) begin
                errors++;
                $display("FAIL idle_no_trigger cyc=%0d got %h/%h exp %h/0", i, got, rdaddr,
                         IDLE_VEC);
            end
        end
    endtask

    task automatic test_scan(input int rep0, input int ncyc, input bit chaos,
                             input int change_at, input int change_val, input bit do_rst);
        int rep_q[0:7];
        int ea;
        logic [27:0] ev, got;
        if (do_rst) do_reset();
        repeat ($urandom_range(0, 4)) @(negedge clock);
        start_run(rep0);
        rep_q[0] = rep0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            model(k, rep_q[k / FT], ea, ev);
            checks++;
            if (int'(rdaddr) !== ea) begin
                errors++;
                $display("FAIL scan_rdaddr k=%0d got %0d exp %0d", k, rdaddr, ea);
            end
            if (k >= 2) model(k - 2, rep_q[(k - 2) / FT], ea, ev);
            else ev = IDLE_VEC;
            got = {red, green, blue, hsync, vsync, DrawArea, frame_start};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL scan_out k=%0d got %h exp %h", k, got, ev);
            end
            if (k == change_at) line_repeat = 2'(change_val);
            if (chaos) begin
                line_repeat = 2'($urandom);
                starttrigger = ($urandom_range(0, 3) == 0);
            end
            // the value present at the frame-wrap edge governs the next frame
            if (k % FT == FT - 1 && k / FT + 1 < 8) rep_q[k / FT + 1] = int'(line_repeat);
        end
        starttrigger = 1'b0;
    endtask

    task automatic test_sync_counts();
        int hs_low, vs_low, vs_edges, vs_bad;
        logic ph, pv;
        hs_low = 0; vs_low = 0; vs_edges = 0; vs_bad = 0;
        ph = 1'b1; pv = 1'b1;
        do_reset();
        start_run(0);
        for (int k = 0; k < FT + 2; k++) begin
            @(negedge clock);
            if (k >= 2) begin
                if (hsync == H_POL) hs_low++;
                if (vsync == V_POL) vs_low++;
                if (k >= 3 && vsync !== pv) begin
                    vs_edges++;
                    if (!(ph == ~H_POL && hsync == H_POL)) vs_bad++;
                end
            end
            ph = hsync;
            pv = vsync;
        end
        checks++;
        if (hs_low !== VT * HSY) begin
            errors++;
            $display("FAIL hsync_active_count got %0d exp %0d", hs_low, VT * HSY);
        end
        checks++;
        if (vs_low !== VSY * HT) begin
            errors++;
            $display("FAIL vsync_active_count got %0d exp %0d", vs_low, VSY * HT);
        end
        checks++;
        if (vs_edges !== 2) begin
            errors++;
            $display("FAIL vsync_edge_count got %0d exp 2", vs_edges);
        end
        checks++;
        if (vs_bad !== 0) begin
            errors++;
            $display("FAIL vsync_edge_on_hsync got %0d misaligned exp 0", vs_bad);
        end
    endtask

    task automatic test_reset_midframe();
        int r, ea;
        logic [27:0] ev, got;
        r = $urandom_range(0, 3);
        do_reset();
        start_run(r);
        for (int k = 0; k <= 2 * HT + 5; k++) @(negedge clock);
        model(2 * HT + 5, r, ea, ev);
        checks++;
        if (int'(rdaddr) !== ea) begin
            errors++;
            $display("FAIL midframe_rdaddr got %0d exp %0d", rdaddr, ea);
        end
        reset = 1'b0;
        starttrigger = 1'b1;
        @(posedge clock);
        #1;
        got = {red, green, blue, hsync, vsync, DrawArea, frame_start};
        checks++;
        if (got !== IDLE_VEC || rdaddr !== '0) begin
            errors++;
            $display("FAIL midframe_reset got %h/%h exp %h/0", got, rdaddr, IDLE_VEC);
        end
        @(negedge clock);
        reset = 1'b1;
        starttrigger = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            got = {red, green, blue, hsync, vsync, DrawArea, frame_start};
            checks++;
            if (got !== IDLE_VEC || rdaddr !== '0) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d got %h/%h exp %h/0", i, got, rdaddr,
                         IDLE_VEC);
            end
        end
        test_scan($urandom_range(0, 3), FT + 6, 1'b0, -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_scan(0, FT + 10, 1'b0, -1, 0, 1'b1);
        test_scan(1, FT + 10, 1'b0, -1, 0, 1'b1);
        test_scan(0, 2 * FT + 10, 1'b0, 40, 3, 1'b1);
        test_sync_counts();
        for (int i = 0; i < 3; i++) test_scan($urandom_range(0, 3), 2 * FT + 5, 1'b1, -1, 0, 1'b1);
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
